chip_run_ctrl: RTL and testbench
================================

# chip_run_ctrl

Run controller that sequences the single-cycle `yChip` datapath. It loads the entry point with a one-cycle `INT` pulse, then advances the chip one instruction per enabled clock. Runs continue freely or in single-step mode, and stop on an instruction budget, an `EBREAK` fetch, or an external abort. It sits between the system/debug front end and `yChip` and owns the chip's `INT`, entry-point and advance-enable inputs.

## Interface
Parameters:
- `EBREAK`, 32'h00100073: instruction word that halts the run.
- `CW`, 16: width of the instruction budget and retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request to begin a run; sampled in IDLE and DONE.
- `entry`  in  32  entry-point address; latched on accepted `start`.
- `max_count`  in  CW  instruction budget; latched on accepted `start`; 0 means unlimited.
- `step_mode`  in  1  latched on accepted `start`; 1 means advance only on `step`.
- `step`  in  1  single-step request; meaningful in RUN when step mode is latched.
- `abort`  in  1  stop the run; meaningful in RUN only.
- `ins`  in  32  current instruction word from `yChip`.
- `chip_int`  out  1  drives `yChip` INT.
- `chip_entry`  out  32  drives `yChip` entryPoint (latched `entry`).
- `chip_en`  out  1  advance enable (clock enable) for `yChip`.
- `busy`  out  1  high in INIT and RUN.
- `done`  out  1  high in DONE.
- `halt_cause`  out  2  why the run stopped: 00 none, 01 budget reached, 10 EBREAK, 11 abort.
- `ins_count`  out  CW  instructions advanced since INIT.

## Operation
- States: IDLE, INIT, RUN, DONE.
- IDLE:
  - `chip_en` = `chip_int` = 0.
  - `start` latches `entry`, `max_count` and `step_mode`, then goes to INIT.
- INIT lasts exactly one cycle:
  - `chip_int` = 1 and `chip_en` = 1, so the chip loads `chip_entry` and fetches.
  - `ins_count` is cleared to 0 and `halt_cause` to 00.
  - Next state is RUN.
- RUN evaluates these conditions each cycle in priority order:
  1. `abort` gives `chip_en` = 0; next state DONE, `halt_cause` = 11.
  2. `ins` == `EBREAK` gives `chip_en` = 0; next state DONE, `halt_cause` = 10. The EBREAK instruction is not counted.
  3. Latched `max_count` != 0 and `ins_count` == `max_count` gives `chip_en` = 0; next state DONE, `halt_cause` = 01.
  4. Step mode latched and `step` = 0 gives `chip_en` = 0; stay in RUN.
  5. Otherwise `chip_en` = 1, `ins_count` increments by 1, stay in RUN.
- `ins_count` wraps modulo 2^CW when the budget is unlimited. It never wraps otherwise, because the run stops when `ins_count` == `max_count`.
- DONE:
  - `chip_en` = 0; `halt_cause` and `ins_count` hold.
  - `start` relatches the inputs and goes to INIT, which starts a new run.
- `start` in INIT or RUN is ignored. `step` and `abort` outside RUN are ignored.
- `chip_int` is never asserted outside INIT.

## Timing
- Reset (asynchronous, immediate):
  - State is IDLE.
  - All outputs are 0: `chip_int`, `chip_en`, `busy`, `done`, `halt_cause`, `ins_count`, `chip_entry`.
- Reset mid-run aborts without a DONE state and without a cause being recorded.
- `chip_en` and `chip_int` are combinational from state and the current-cycle `ins`, `ins_count`, `step` and `abort`. All other outputs are registered.
- Latency:
  - `start` at edge N gives INIT in cycle N+1.
  - The first fetch edge is at the end of INIT.
  - The first RUN cycle sees the instruction at `entry`.
- A run of K instructions (free mode, no halt) takes 1 INIT cycle plus K enabled RUN cycles. DONE is entered on the edge ending the RUN cycle where the budget condition is seen.
- Step mode: each cycle with `step` = 1 advances exactly one instruction. Holding `step` high advances one instruction per cycle.
- Simultaneous events in the same RUN cycle: abort beats EBREAK, which beats budget, which beats step. With `abort` and `step` both high, no advance occurs.

## Test plan
- Free run: `entry`=128, `max_count`=43, `step_mode`=0, program with no EBREAK, `start` pulse -> `chip_int` high for exactly 1 cycle, 43 `chip_en` cycles in RUN, then `done`=1, `halt_cause`=01, `ins_count`=43.
- EBREAK: `entry`=128, `max_count`=0, EBREAK at the 6th instruction -> `chip_en` low when EBREAK is on `ins`, `halt_cause`=10, `ins_count`=5.
- Single step: `step_mode`=1, `max_count`=3, three `step` pulses spaced 4 cycles apart -> `ins_count` goes 1, 2, 3 one cycle after each pulse, `chip_en` high only in the pulse cycles; DONE, cause 01, after the 3rd.
- Abort vs EBREAK: assert `abort` in the same cycle `ins`=EBREAK -> `halt_cause`=11, `chip_en`=0.
- Reset mid-run: drop `rst_n` at instruction 10 -> all outputs 0 immediately, state IDLE. A new `start` with `entry`=256 pulses `chip_int` once, `chip_entry`=256, `ins_count` restarts at 0.
- Restart/ignore: `start` during RUN -> no effect. `start` in DONE -> INIT next cycle, `halt_cause` cleared to 00.

Source files
------------

// File: rtl/chip_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : chip_run_ctrl
//  Purpose  : Run controller for the single-cycle yChip datapath. Loads the
//             entry point with a one-cycle INT pulse and then advances the
//             chip one instruction per enabled cycle, either freely or in
//             single-step mode. A run stops on an instruction budget, an
//             EBREAK fetch or an external abort.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             start                  - begin a run (accepted in IDLE/DONE)
//             entry, max_count,
//             step_mode              - run setup, latched on accepted start
//             step, abort            - run-time controls (RUN only)
//             ins                    - current instruction word from yChip
//             chip_int, chip_entry,
//             chip_en                - yChip INT, entryPoint, advance enable
//             busy, done             - INIT/RUN and DONE indicators
//             halt_cause             - 00 none, 01 budget, 10 EBREAK, 11 abort
//             ins_count              - instructions advanced since INIT
//  Revision : 1.0 - initial release
// ============================================================================
module chip_run_ctrl #(
    parameter logic [31:0] EBREAK = 32'h00100073,
    parameter int          CW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   entry,
    input  logic [CW-1:0] max_count,
    input  logic          step_mode,
    input  logic          step,
    input  logic          abort,
    input  logic [31:0]   ins,
    output logic          chip_int,
    output logic [31:0]   chip_entry,
    output logic          chip_en,
    output logic          busy,
    output logic          done,
    output logic [1:0]    halt_cause,
    output logic [CW-1:0] ins_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BUDGET = 2'b01;
    localparam logic [1:0] CAUSE_EBREAK = 2'b10;
    localparam logic [1:0] CAUSE_ABORT  = 2'b11;

    state_t        state_q, state_d;
    logic [31:0]   entry_q, entry_d;
    logic [CW-1:0] max_q, max_d;
    logic          step_mode_q, step_mode_d;
    logic [1:0]    cause_q, cause_d;
    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            max_q       <= '0;
            step_mode_q <= 1'b0;
            cause_q     <= CAUSE_NONE;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            max_q       <= max_d;
            step_mode_q <= step_mode_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        max_d       = max_q;
        step_mode_d = step_mode_q;
        cause_d     = cause_q;
        count_d     = count_q;
        chip_int    = 1'b0;
        chip_en     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Counter and cause are cleared as the run is accepted so
                // they already read zero during the INIT cycle.
                if (start) begin
                    entry_d     = entry;
                    max_d       = max_count;
                    step_mode_d = step_mode;
                    count_d     = '0;
                    cause_d     = CAUSE_NONE;
                    state_d     = ST_INIT;
                end
            end
            ST_INIT: begin
                // INT with enable makes the chip load entry and fetch.
                chip_int = 1'b1;
                chip_en  = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    cause_d = CAUSE_ABORT;
                    state_d = ST_DONE;
                end else if (ins == EBREAK) begin
                    cause_d = CAUSE_EBREAK;
                    state_d = ST_DONE;
                end else if ((max_q != '0) && (count_q == max_q)) begin
                    cause_d = CAUSE_BUDGET;
                    state_d = ST_DONE;
                end else if (step_mode_q && !step) begin
                    state_d = ST_RUN;
                end else begin
                    chip_en = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign chip_entry = entry_q;
    assign busy       = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign halt_cause = cause_q;
    assign ins_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_chip_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chip_run_ctrl
//  Purpose  : Self-checking bench for chip_run_ctrl. A small yChip model
//             (program memory + PC) feeds ins; a behavioural run model
//             predicts enables and registered outputs every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chip_run_ctrl;

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam int          CW     = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   entry = '0;
    logic [CW-1:0] max_count = '0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   ins = '0;
    logic          chip_int, chip_en, busy, done;
    logic [31:0]   chip_entry;
    logic [1:0]    halt_cause;
    logic [CW-1:0] ins_count;

    chip_run_ctrl #(.EBREAK(EBREAK), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .entry(entry),
        .max_count(max_count), .step_mode(step_mode), .step(step),
        .abort(abort), .ins(ins), .chip_int(chip_int),
        .chip_entry(chip_entry), .chip_en(chip_en), .busy(busy),
        .done(done), .halt_cause(halt_cause), .ins_count(ins_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- chip model: program memory and PC ----------------
    logic [31:0] prog [1024];
    logic [31:0] pc = '0;

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == EBREAK) w = 32'h00000013;
        return w;
    endfunction

    task automatic fill_prog(input int ebreak_one_in);
        for (int i = 0; i < 1024; i++) begin
            if (ebreak_one_in != 0 && $urandom_range(ebreak_one_in - 1, 0) == 0)
                prog[i] = EBREAK;
            else
                prog[i] = rand_word();
        end
    endtask

    // ---------------- behavioural run model ----------------
    // phase: 0 waiting (never run), 1 loading, 2 running, 3 finished
    int          m_phase = 0;
    logic [31:0] m_entry = '0;
    int          m_max = 0;
    bit          m_stepm = 0;
    int          m_cause = 0;
    int          m_cnt = 0;
    bit          e_en, e_int;
    int          n_int = 0;
    int          n_en_run = 0;

    task automatic model_reset();
        m_phase = 0; m_entry = '0; m_max = 0; m_stepm = 0; m_cause = 0; m_cnt = 0;
    endtask

    // Evaluate one cycle: predict enables for this cycle, then the outcome
    // of the coming edge (including the chip's PC).
    task automatic model_cycle();
        e_en = 0; e_int = 0;
        if (m_phase == 1) begin
            e_en = 1; e_int = 1;
            pc = m_entry;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (abort)                                begin m_cause = 3; m_phase = 3; end
            else if (ins == EBREAK)                   begin m_cause = 2; m_phase = 3; end
            else if (m_max != 0 && m_cnt == m_max)    begin m_cause = 1; m_phase = 3; end
            else if (m_stepm && !step)                begin end
            else begin
                e_en = 1;
                m_cnt = (m_cnt + 1) % (1 << CW);
                pc = pc + 4;
            end
        end else if (start) begin
            m_entry = entry; m_max = int'(max_count); m_stepm = step_mode;
            m_cnt = 0; m_cause = 0; m_phase = 1;
        end
    endtask

    // One clock: inputs are already driven (just after a falling edge).
    task automatic tick();
        bit was_run;
        #1;
        was_run = (m_phase == 2);
        model_cycle();
        chk("chip_en", {31'b0, chip_en}, {31'b0, e_en});
        chk("chip_int", {31'b0, chip_int}, {31'b0, e_int});
        if (chip_int) n_int++;
        if (was_run && chip_en) n_en_run++;
        @(posedge clk);
        @(negedge clk);
        ins = prog[pc[11:2]];
        chk("busy", {31'b0, busy}, {31'b0, (m_phase == 1 || m_phase == 2)});
        chk("done", {31'b0, done}, {31'b0, (m_phase == 3)});
        chk("halt_cause", {30'b0, halt_cause}, m_cause);
        chk("ins_count", {16'b0, ins_count}, m_cnt);
        chk("chip_entry", chip_entry, m_entry);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {chip_int, chip_en, busy, done, halt_cause},  6'd0);
        chk({tag, "_cnt"}, {16'b0, ins_count}, 0);
        chk({tag, "_entry"}, chip_entry, 0);
    endtask

    // ---------------- table of directed runs ----------------
    typedef struct {
        logic [31:0] entry;
        int          max;
        bit          stepm;
        int          ebreak_at;   // 1-based instruction index, 0 = none
        int          abort_at;    // 1-based RUN cycle, 0 = none
        int          exp_cause;
        int          exp_cnt;
    } run_vec_t;

    run_vec_t vecs [7];

    task automatic run_case(input run_vec_t v);
        int run_seen;
        fill_prog(0);
        if (v.ebreak_at != 0) prog[(v.entry >> 2) + v.ebreak_at - 1] = EBREAK;
        ins = prog[pc[11:2]];
        entry = v.entry; max_count = CW'(v.max); step_mode = v.stepm; start = 1'b1;
        n_int = 0; n_en_run = 0; run_seen = 0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300 && m_phase != 3; c++) begin
            // single-step pulses every 4 cycles starting at the first RUN cycle
            step  = (m_phase == 2) && ((run_seen % 4) == 0);
            abort = (m_phase == 2) && (v.abort_at == run_seen + 1);
            if (m_phase == 2) run_seen++;
            tick();
        end
        step = 1'b0; abort = 1'b0;
        chk("case_done", {31'b0, done}, 1);
        chk("case_cause", {30'b0, halt_cause}, v.exp_cause);
        chk("case_count", {16'b0, ins_count}, v.exp_cnt);
        chk("case_int_pulses", n_int, 1);
        chk("case_run_enables", n_en_run, v.exp_cnt);
    endtask

    initial begin
        vecs[0] = '{32'd128, 43, 1'b0, 0,  0, 1, 43};  // free run to budget
        vecs[1] = '{32'd128, 0,  1'b0, 6,  0, 2, 5};   // EBREAK at 6th
        vecs[2] = '{32'd64,  3,  1'b1, 0,  0, 1, 3};   // single step, spaced pulses
        vecs[3] = '{32'd128, 0,  1'b0, 4,  4, 3, 3};   // abort beats EBREAK
        vecs[4] = '{32'd512, 1,  1'b0, 0,  0, 1, 1};   // smallest budget
        vecs[5] = '{32'd0,   10, 1'b0, 11, 0, 2, 10};  // EBREAK beats budget
        vecs[6] = '{32'd256, 0,  1'b0, 0,  1, 3, 0};   // abort in first RUN cycle

        fill_prog(0);
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_case(vecs[i]);

        // start in DONE restarts immediately with the cause cleared
        entry = 32'd1024; max_count = 16'd0; step_mode = 1'b0; start = 1'b1;
        tick();
        chk("restart_busy", {31'b0, busy}, 1);
        chk("restart_cause", {30'b0, halt_cause}, 0);
        start = 1'b0;
        tick(); tick();
        // start during RUN must be ignored
        entry = 32'd2048; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        chk("run_ignores_start", chip_entry, 32'd1024);
        chk("run_ignores_start_cnt", {16'b0, ins_count}, 3);

        // reset in the middle of a run, 10 instructions in
        for (int c = 0; c < 20 && m_cnt < 10; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("after_reset_idle");
        run_case('{32'd256, 5, 1'b0, 0, 0, 1, 5});

        // randomized traffic
        fill_prog(12);
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(3, 0) == 0);
            entry     = {20'b0, 10'($urandom), 2'b00};
            max_count = CW'($urandom_range(12, 0));
            step_mode = $urandom_range(1, 0);
            step      = $urandom_range(1, 0);
            abort     = ($urandom_range(24, 0) == 0);
            tick();
        end
        start = 1'b0; step = 1'b0; abort = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
